mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multi-cycle control unit that sequences the shared 32-bit ALU, register file, instruction/data memory and PC of the multi-cycle RV32 core. It is a Moore FSM with a combinational ALU decoder and immediate-select decoder. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the ALU's 3-bit `ALUControl` in every cycle. It samples the ALU `Zero` flag to resolve `beq`.

## Interface
Parameters: none (the state and opcode encodings below are fixed).
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `op`  in  7  instruction opcode, `Instr[6:0]`, from the instruction register
- `funct3`  in  3  `Instr[14:12]`
- `funct7b5`  in  1  `Instr[30]`
- `Zero`  in  1  ALU zero flag, same cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result
- `MemWrite`  out  1  data memory write enable
- `IRWrite`  out  1  instruction register (and OldPC) enable
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = memory Data, 10 = ALUResult
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = register A
- `ALUSrcB`  out  2  ALU B select: 00 = register WriteData, 01 = ImmExt, 10 = constant 4
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- `RegWrite`  out  1  register file write enable
- `ALUControl`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor, 110 slt, 111 sltu
- `state`  out  4  current state, for debug and verification

## Operation
- Supported opcodes: `lw` 0000011, `sw` 0100011, R-type 0110011, I-ALU 0010011, `beq` 1100011, `jal` 1101111.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 return to FETCH on the next clock.
- Per-state outputs. Any output not listed is 0. ALUOp is internal, 2 bits.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next by opcode:
    - `lw`/`sw` → MEMADR
    - R-type → EXECUTER
    - I-ALU → EXECUTEI
    - `beq` → BEQ
    - `jal` → JAL
    - any other opcode → FETCH (instruction treated as a no-op)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: `lw` → MEMREAD, `sw` → MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- PCWrite = PCUpdate | (Branch & Zero).
- ALU decoder:
  - ALUOp 00 → 000 (add)
  - ALUOp 01 → 001 (sub)
  - ALUOp 11 → 000 (add)
  - ALUOp 10, decoded by funct3:
    - 000 → 001 (sub) if {op[5], funct7b5} = 11, else 000 (add); so `addi` with Instr[30]=1 still adds
    - 010 → 110 (slt)
    - 011 → 111 (sltu)
    - 100 → 100 (xor)
    - 110 → 011 (or)
    - 111 → 010 (and)
    - 001 or 101 (shifts, unsupported) → 000 (add)
  - NOR (101) is never generated.
- ImmSrc is decoded from `op` alone, independent of state:
  - `lw`, I-ALU → 00
  - `sw` → 01
  - `beq` → 10
  - `jal` → 11
  - other opcodes → 00

## Timing
- The state register updates on the rising edge of `clk`.
- Reset:
  - `reset` high at an edge → state = FETCH, regardless of current state; this applies mid-instruction too.
  - While `reset` is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - All other outputs follow FETCH decoding once the state is FETCH.
  - After reset is released, the first FETCH cycle asserts IRWrite=1 and PCWrite=1.
- Cycles per instruction, counted from the FETCH cycle:
  - `lw` 5
  - `sw` 4
  - R-type 4
  - I-ALU 4
  - `jal` 4
  - `beq` 3
  - unsupported opcode 2
- Outputs and ALUControl are combinational from `state`, `op`, `funct3`, `funct7b5` and `Zero`. There are no output registers.
- `Zero` is used only in BEQ, in the same cycle. `Zero` is a don't-care in every other state.
- `op`, `funct3` and `funct7b5` must be stable from DECODE until the instruction returns to FETCH. The IR is written only in FETCH, so this holds.

## Test plan
- Reset: assert `reset` for 2 cycles while in MEMREAD → state=0; IRWrite=PCWrite=RegWrite=MemWrite=0 while reset is high; after release, IRWrite=1, PCWrite=1, ALUSrcB=10, ALUControl=000.
- `lw` (op 0000011): state sequence 0,1,2,3,4,0. MEMADR has ALUSrcA=10, ALUSrcB=01, ALUControl=000, ImmSrc=00. MEMWB has ResultSrc=01, RegWrite=1. RegWrite=1 in exactly one cycle.
- `sw` (op 0100011): sequence 0,1,2,5,0. MemWrite=1 only in state 5, with AdrSrc=1 and ImmSrc=01.
- R-type sweep (op 0110011) through EXECUTER:
  - funct3=000, funct7b5=1 → ALUControl=001; funct7b5=0 → 000
  - funct3=111 → 010; 110 → 011; 100 → 100; 010 → 110; 011 → 111
  - `addi` (op 0010011, funct3=000, funct7b5=1) in EXECUTEI → 000
- `beq` (op 1100011): in state 9, ALUControl=001 and ImmSrc=10. Zero=1 → PCWrite=1; Zero=0 → PCWrite=0. Next state is 0.
- `jal` (op 1101111): sequence 0,1,10,8,0. In state 10, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ImmSrc=11. In state 8, RegWrite=1. Unsupported op 0000000: sequence 0,1,0 with no write enables in DECODE.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32 control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback. It also contains the ALU decoder and the
// immediate-format decoder.
module mc_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state_q, state_d;
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;

  // State register; reset forces FETCH from any state
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Next-state and per-state Moore outputs
  always_comb begin
    state_d       = S_FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    alu_op        = 2'b00;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        pc_update    = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables, suppressed while reset is held
  always_comb begin
    PCWrite  = pc_update | (branch & Zero);
    IRWrite  = ir_write_raw;
    MemWrite = mem_write_raw;
    RegWrite = reg_write_raw;
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // ALU decoder: ALUOp plus funct fields to ALU operation
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b110;
          3'b011:  ALUControl = 3'b111;
          3'b100:  ALUControl = 3'b100;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format decoded from opcode alone
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: an instruction-level reference
// model predicts the state walk and all outputs, compared every cycle.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .state(state)
  );

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] rsrc;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] imm;
    logic       regw;
    logic [2:0] aluc;
  } exp_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_state = 0;
  logic        chk_en = 1'b0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
  endtask

  // Operation requested for register-register / register-immediate ALU work
  function automatic logic [2:0] alu_fn(input logic [2:0] f3, input logic op5, input logic f7);
    case (f3)
      3'b000:  return (op5 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b110;
      3'b011:  return 3'b111;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Number of cycles an instruction occupies, starting at FETCH
  function automatic int unsigned seq_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default:    return 2;
    endcase
  endfunction

  // State code expected in cycle i of an instruction
  function automatic int unsigned seq_at(input logic [6:0] o, input int unsigned i);
    int unsigned t[5];
    case (o)
      7'b0000011: t = '{0, 1, 2, 3, 4};
      7'b0100011: t = '{0, 1, 2, 5, 0};
      7'b0110011: t = '{0, 1, 6, 8, 0};
      7'b0010011: t = '{0, 1, 7, 8, 0};
      7'b1100011: t = '{0, 1, 9, 0, 0};
      7'b1101111: t = '{0, 1, 10, 8, 0};
      default:    t = '{0, 1, 0, 0, 0};
    endcase
    return t[i];
  endfunction

  // Outputs required for a given state code and instruction fields
  function automatic exp_t model_out(input int unsigned s, input logic [6:0] o,
                                     input logic [2:0] f3, input logic f7,
                                     input logic z, input logic r);
    exp_t e;
    e = '0;
    case (s)
      0:  begin e.irw = 1; e.asb = 2'b10; e.rsrc = 2'b10; e.pcw = 1; end
      1:  begin e.asa = 2'b01; e.asb = 2'b01; end
      2:  begin e.asa = 2'b10; e.asb = 2'b01; end
      3:  begin e.adr = 1; end
      4:  begin e.rsrc = 2'b01; e.regw = 1; end
      5:  begin e.adr = 1; e.memw = 1; end
      6:  begin e.asa = 2'b10; e.asb = 2'b00; end
      7:  begin e.asa = 2'b10; e.asb = 2'b01; end
      8:  begin e.regw = 1; end
      9:  begin e.asa = 2'b10; e.pcw = z; end
      10: begin e.asa = 2'b01; e.asb = 2'b10; e.pcw = 1; end
      default: ;
    endcase
    if (s == 6 || s == 7) e.aluc = alu_fn(f3, o[5], f7);
    else if (s == 9)      e.aluc = 3'b001;
    else                  e.aluc = 3'b000;
    case (o)
      7'b0100011: e.imm = 2'b01;
      7'b1100011: e.imm = 2'b10;
      7'b1101111: e.imm = 2'b11;
      default:    e.imm = 2'b00;
    endcase
    if (r) begin
      e.pcw = 0; e.irw = 0; e.memw = 0; e.regw = 0;
    end
    return e;
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = model_out(exp_state, op, funct3, funct7b5, Zero, reset);
      chk("state",      state,      exp_state);
      chk("PCWrite",    PCWrite,    e.pcw);
      chk("AdrSrc",     AdrSrc,     e.adr);
      chk("MemWrite",   MemWrite,   e.memw);
      chk("IRWrite",    IRWrite,    e.irw);
      chk("ResultSrc",  ResultSrc,  e.rsrc);
      chk("ALUSrcA",    ALUSrcA,    e.asa);
      chk("ALUSrcB",    ALUSrcB,    e.asb);
      chk("ImmSrc",     ImmSrc,     e.imm);
      chk("RegWrite",   RegWrite,   e.regw);
      chk("ALUControl", ALUControl, e.aluc);
    end
  end

  // Run one instruction; optionally assert reset at cycle abort_at for
  // rst_len cycles, and pin {PCWrite, ALUControl} to a literal at pin_idx.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int zmode, input int abort_at, input int rst_len,
                           input int pin_idx, input logic [3:0] pin_val);
    int unsigned n;
    n = seq_len(o);
    for (int i = 0; i < int'(n); i++) begin
      if (i == 0) begin
        op = o; funct3 = f3; funct7b5 = f7;
      end
      Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      exp_state = seq_at(o, i);
      if (i == pin_idx) begin
        #1;
        chk("pin_pcw_aluc", {PCWrite, ALUControl}, pin_val);
      end
      if (i == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k < rst_len; k++) begin
          exp_state = 0;
          @(posedge clk); #1;
        end
        reset = 1'b0;
        exp_state = 0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [6:0] ops[7];
    logic [3:0] sweep[7];
    logic [6:0] o;
    int         ab;

    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b0000000};
    // {funct3, funct7b5} with expected ALUControl in EXECUTER
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_state = 0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // First FETCH after reset release
    run_instr(7'b0000011, 3'b010, 1'b0, 0, -1, 0, 0, 4'b1000);
    // lw interrupted in MEMREAD by a two-cycle reset
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, 2, -1, 4'b0000);
    run_instr(7'b0100011, 3'b010, 1'b0, 0, -1, 0, 0, 4'b1000);
    run_instr(7'b0100011, 3'b010, 1'b0, 2, -1, 0, -1, 4'b0000);

    // R-type sweep through EXECUTER
    for (int j = 0; j < 7; j++) begin
      case (j)
        0: begin o = 7'b0110011; sweep[j] = 4'b0001; run_instr(o, 3'b000, 1'b1, 2, -1, 0, 2, 4'b0001); end
        1: begin o = 7'b0110011; sweep[j] = 4'b0000; run_instr(o, 3'b000, 1'b0, 2, -1, 0, 2, 4'b0000); end
        2: begin o = 7'b0110011; sweep[j] = 4'b0010; run_instr(o, 3'b111, 1'b0, 2, -1, 0, 2, 4'b0010); end
        3: begin o = 7'b0110011; sweep[j] = 4'b0011; run_instr(o, 3'b110, 1'b0, 2, -1, 0, 2, 4'b0011); end
        4: begin o = 7'b0110011; sweep[j] = 4'b0100; run_instr(o, 3'b100, 1'b0, 2, -1, 0, 2, 4'b0100); end
        5: begin o = 7'b0110011; sweep[j] = 4'b0110; run_instr(o, 3'b010, 1'b0, 2, -1, 0, 2, 4'b0110); end
        default: begin o = 7'b0110011; sweep[j] = 4'b0111; run_instr(o, 3'b011, 1'b0, 2, -1, 0, 2, 4'b0111); end
      endcase
    end
    // addi with Instr[30]=1 still adds
    run_instr(7'b0010011, 3'b000, 1'b1, 2, -1, 0, 2, 4'b0000);
    // beq taken and not taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1, -1, 0, 2, 4'b1001);
    run_instr(7'b1100011, 3'b000, 1'b0, 0, -1, 0, 2, 4'b0001);
    // jal, then unsupported opcode
    run_instr(7'b1101111, 3'b000, 1'b0, 2, -1, 0, 2, 4'b1000);
    run_instr(7'b0000000, 3'b000, 1'b0, 2, -1, 0, 1, 4'b0000);

    // Randomized instruction stream with occasional mid-instruction resets
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 7) == 0) o = 7'($urandom);
      else o = ops[$urandom_range(0, 6)];
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, seq_len(o) - 1)) : -1;
      run_instr(o, 3'($urandom), 1'($urandom), 2, ab, int'($urandom_range(1, 2)), -1, 4'b0000);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
